// File: rtl/branch_predict_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : branch_predict_unit                                            |
// | Purpose : Direct-mapped BTB with 2-bit direction counters for fetch,     |
// |           plus branch condition evaluation, misprediction detection,     |
// |           table training and saturating statistics for execute.          |
// | Ports   : clk, reset (async, active-high)                                |
// |           if_pc -> pred_taken, pred_target          (fetch lookup)       |
// |           res_valid/res_pc/res_rs/res_rt/res_type/res_target/            |
// |           res_pred_target -> res_taken, mispredict, redirect_pc          |
// |           branch_cnt, mispred_cnt                   (statistics)         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module branch_predict_unit #(
  parameter int WORD_SIZE   = 16,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int PREDICT_EN  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] if_pc,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  input  logic                 res_valid,
  input  logic [WORD_SIZE-1:0] res_pc,
  input  logic [WORD_SIZE-1:0] res_rs,
  input  logic [WORD_SIZE-1:0] res_rt,
  input  logic [2:0]           res_type,
  input  logic [WORD_SIZE-1:0] res_target,
  input  logic [WORD_SIZE-1:0] res_pred_target,
  output logic                 res_taken,
  output logic                 mispredict,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam int IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_BITS = WORD_SIZE - IDX_BITS;

  // Conditional-branch encodings in res_type[1:0]
  localparam logic [1:0] C_BNE = 2'b00;
  localparam logic [1:0] C_BEQ = 2'b01;
  localparam logic [1:0] C_BGZ = 2'b10;
  localparam logic [1:0] C_BLZ = 2'b11;

  localparam logic [1:0] C_CTR_RESET = 2'b01;
  localparam logic [1:0] C_CTR_MAX   = 2'b11;
  localparam logic [1:0] C_CTR_WEAK  = 2'b10;

  // Table state
  logic                 valid_q  [BTB_ENTRIES];
  logic                 valid_d  [BTB_ENTRIES];
  logic [TAG_BITS-1:0]  tag_q    [BTB_ENTRIES];
  logic [TAG_BITS-1:0]  tag_d    [BTB_ENTRIES];
  logic [WORD_SIZE-1:0] target_q [BTB_ENTRIES];
  logic [WORD_SIZE-1:0] target_d [BTB_ENTRIES];
  logic [1:0]           ctr_q    [BTB_ENTRIES];
  logic [1:0]           ctr_d    [BTB_ENTRIES];

  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  // ---------------------------------------------------------------- lookup
  logic [IDX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0] w_if_tag;
  logic                w_if_hit;

  assign w_if_idx = if_pc[IDX_BITS-1:0];
  assign w_if_tag = if_pc[WORD_SIZE-1:IDX_BITS];
  assign w_if_hit = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);

  assign pred_taken  = (PREDICT_EN != 0) && !reset && w_if_hit && ctr_q[w_if_idx][1];
  assign pred_target = pred_taken ? target_q[w_if_idx] : if_pc + WORD_SIZE'(1);

  // ------------------------------------------------------------ resolution
  logic                 w_cond;
  logic [WORD_SIZE-1:0] w_actual;

  always_comb begin
    w_cond = 1'b1;
    if (res_type[2]) begin
      case (res_type[1:0])
        C_BNE:   w_cond = (res_rs != res_rt);
        C_BEQ:   w_cond = (res_rs == res_rt);
        C_BGZ:   w_cond = !res_rs[WORD_SIZE-1] && (res_rs != '0);
        C_BLZ:   w_cond = res_rs[WORD_SIZE-1];
        default: w_cond = 1'b0;
      endcase
    end
  end

  assign res_taken   = res_valid && !reset && w_cond;
  assign w_actual    = res_taken ? res_target : res_pc + WORD_SIZE'(1);
  assign redirect_pc = w_actual;
  assign mispredict  = res_valid && !reset && (w_actual != res_pred_target);

  // -------------------------------------------------------------- training
  logic [IDX_BITS-1:0] w_res_idx;
  logic [TAG_BITS-1:0] w_res_tag;
  logic                w_res_hit;
  logic                w_train;

  assign w_res_idx = res_pc[IDX_BITS-1:0];
  assign w_res_tag = res_pc[WORD_SIZE-1:IDX_BITS];
  assign w_res_hit = valid_q[w_res_idx] && (tag_q[w_res_idx] == w_res_tag);
  assign w_train   = res_valid && (PREDICT_EN != 0);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (w_train) begin
      if (res_taken) begin
        if (w_res_hit) begin
          if (ctr_q[w_res_idx] != C_CTR_MAX) begin
            ctr_d[w_res_idx] = ctr_q[w_res_idx] + 2'd1;
          end
          target_d[w_res_idx] = res_target;
        end else begin
          // Allocate / replace: jumps start strongly taken, branches weakly
          valid_d[w_res_idx]  = 1'b1;
          tag_d[w_res_idx]    = w_res_tag;
          target_d[w_res_idx] = res_target;
          ctr_d[w_res_idx]    = res_type[2] ? C_CTR_WEAK : C_CTR_MAX;
        end
      end else if (w_res_hit && (ctr_q[w_res_idx] != 2'b00)) begin
        ctr_d[w_res_idx] = ctr_q[w_res_idx] - 2'd1;
      end
    end
  end

  // ------------------------------------------------------------ statistics
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res_valid && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
    end
    if (mispredict && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= C_CTR_RESET;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch prediction and resolution unit for the pipelined CPU. Fetch gets a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Decode/execute gets condition evaluation for BNE/BEQ/BGZ/BLZ/jump, misprediction detection with a redirect PC, and table training. Saturating statistics counters support performance measurement.

## Interface
- WORD_SIZE, 16, PC/data width
- BTB_ENTRIES, 16, table depth; power of two, ≥2; IDX_BITS = log2(BTB_ENTRIES)
- CNT_WIDTH, 16, statistics counter width
- PREDICT_EN, 1, 1 = dynamic prediction; 0 = static not-taken (table never written, pred_taken held 0)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- if_pc  in  WORD_SIZE  fetch PC to predict
- pred_taken  out  1  fetch prediction
- pred_target  out  WORD_SIZE  predicted next PC
- res_valid  in  1  a branch/jump resolves this cycle
- res_pc  in  WORD_SIZE  PC of the resolving instruction
- res_rs, res_rt  in  WORD_SIZE  operands
- res_type  in  3  type[2]=0: unconditional; type[2]=1, type[1:0]: 00 BNE, 01 BEQ, 10 BGZ, 11 BLZ
- res_target  in  WORD_SIZE  computed taken target
- res_pred_target  in  WORD_SIZE  next PC the front end actually fetched
- res_taken  out  1  resolved direction
- mispredict  out  1  redirect required
- redirect_pc  out  WORD_SIZE  correct next PC
- branch_cnt, mispred_cnt  out  CNT_WIDTH  statistics

## Operation
- Entry fields: valid, tag = pc[WORD_SIZE-1:IDX_BITS], target, ctr[1:0]. Index = pc[IDX_BITS-1:0]. PC is word-addressed; sequential PC = pc+1 mod 2^WORD_SIZE.
- Lookup (combinational from if_pc and current table):
  - hit = valid && tag match
  - pred_taken = PREDICT_EN && hit && ctr[1]
  - pred_target = pred_taken ? target : if_pc+1
- Condition evaluation (combinational):
  - BNE: rs!=rt
  - BEQ: rs==rt
  - BGZ: rs[MSB]==0 && rs!=0
  - BLZ: rs[MSB]==1
  - unconditional: 1
- actual = res_taken ? res_target : res_pc+1.
- mispredict = res_valid && (actual != res_pred_target). redirect_pc = actual at all times; it is meaningful only when mispredict is high.
- res_taken and mispredict are 0 when res_valid is 0.
- Training, clocked, only when res_valid && PREDICT_EN:
  - Taken, res_pc hits: ctr saturating +1 (11 stays 11); target overwritten with res_target.
  - Taken, miss (invalid or tag mismatch): allocate/replace the entry; valid=1, tag, target; ctr = 11 if unconditional, else 10.
  - Not taken, hit: ctr saturating -1 (00 stays 00).
  - Not taken, miss: no change.
- Statistics, clocked:
  - branch_cnt +1 per res_valid cycle.
  - mispred_cnt +1 per mispredict cycle.
  - Both saturate at all-ones and never wrap.
  - Both are active regardless of PREDICT_EN.
- Same-cycle lookup and update of one index: lookup returns pre-update contents; the update is visible from the next cycle.

## Timing
- Reset (async assert, held until deassert): all valid=0, all ctr=01, targets/tags=0, branch_cnt=mispred_cnt=0.
- Output values under reset: pred_taken=0, pred_target=if_pc+1, res_taken=0, mispredict=0.
- Reset asserted mid-update: the update is discarded and the table is cleared.
- Prediction and resolution outputs: zero latency (combinational). Table and statistics updates: visible one cycle after the res_valid edge.
- One resolution per cycle. No stall input; the pipeline deasserts res_valid for stalled or flushed slots.

## Test plan
- Reset, then if_pc=0x0010 -> pred_taken=0, pred_target=0x0011; branch_cnt=mispred_cnt=0; if_pc=0xFFFF -> pred_target=0x0000 (wrap).
- BEQ at res_pc=0x0020, rs=rt=5, res_target=0x0030, res_pred_target=0x0021 -> res_taken=1, mispredict=1, redirect_pc=0x0030. Next cycle: if_pc=0x0020 -> pred_taken=1, pred_target=0x0030; branch_cnt=1, mispred_cnt=1.
- Hysteresis at 0x0020:
  - taken again -> ctr 11
  - not taken (rs=5, rt=6) -> ctr 10, still predicts taken
  - not taken again -> ctr 01, pred_taken=0, pred_target=0x0021
- Aliasing: allocate 0x0025, then lookup 0x0035 -> miss, pred_target=0x0036. Taken jump (type=000) at 0x0035, target 0x0100 -> entry replaced with ctr 11; lookup 0x0025 now misses.
- Conditions:
  - BGZ rs=0x0000 -> not taken
  - BGZ rs=0x7FFF -> taken
  - BLZ rs=0x8000 -> taken
  - BNE rs=rt=3 -> not taken
  - correct prediction (res_pred_target==actual) -> mispredict=0
- CNT_WIDTH=2: five mispredicting resolutions -> both counters stay 3. PREDICT_EN=0: a taken branch never makes pred_taken high. Reset asserted mid-sequence -> all state cleared asynchronously, before the next clock edge.
